specu_flush_mask_gen: RTL and testbench

//  Speculative-squash mask generator between branch resolution and the reorder buffer.
//  - Input: a one-hot mispredicted-branch tag.
//  - Computes the wrap-aware ROB mask of entries younger than that branch, from the ROB head/tail/full state.
//  - Issues the mask to the ROB over a valid/ack handshake.
//  - Arbitrates overlapping mispredictions so the oldest branch wins.

---
 rtl/specu_flush_mask_gen.sv | 196 +++++++++++++++++++
 tb/tb_specu_flush_mask_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/specu_flush_mask_gen.sv
// -----------------------------------------------------------------------------
// specu_flush_mask_gen
//
// Purpose:
//   This block sits between branch resolution and the reorder buffer and
//   generates the speculative-squash mask for a mispredicted branch. It takes
//   the one-hot ROB tag of the branch and computes which ROB entries are
//   younger than it. The ages are wrap-aware and come from the ROB
//   head, tail and full state. The mask is sent to the ROB over a valid/ack
//   handshake. When mispredicts overlap, the oldest branch wins.
//
// Optional feature (macro SPECU_FLUSH_ONEHOT_CHECK_EN):
//   When defined, the block adds the port onehot_err_out. It pulses one cycle
//   after any mispredict report whose tag is not exactly one-hot. Such a
//   request is dropped. When undefined, the lowest set bit of the tag selects
//   the branch, and an all-zero tag is silently dropped.
//
// Ports:
//   clk             in   1         clock, rising edge
//   rst_n           in   1         asynchronous active-low reset
//   misp_valid_in   in   1         mispredict report valid (single-cycle pulse)
//   misp_tag_in     in   ROB_SIZE  one-hot ROB slot of the mispredicted branch
//   rob_head_in     in   PTR_W     index of the oldest ROB entry
//   rob_tail_in     in   PTR_W     index of the next free ROB slot
//   rob_full_in     in   1         ROB full (tail==head means full, not empty)
//   flush_ack_in    in   1         ROB applied flush_mask_out this cycle
//   onehot_err_out  out  1         malformed tag seen (only with the macro)
//   flush_valid_out out  1         flush_mask_out valid, held until ack
//   flush_mask_out  out  ROB_SIZE  bit i set: squash ROB entry i
//   busy_out        out  1         block not idle; ROB must not dispatch
// -----------------------------------------------------------------------------
module specu_flush_mask_gen #(
  parameter int ROB_SIZE = 16,
  parameter int PTR_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                misp_valid_in,
  input  logic [ROB_SIZE-1:0] misp_tag_in,
  input  logic [PTR_W-1:0]    rob_head_in,
  input  logic [PTR_W-1:0]    rob_tail_in,
  input  logic                rob_full_in,
  input  logic                flush_ack_in,
`ifdef SPECU_FLUSH_ONEHOT_CHECK_EN
  output logic                onehot_err_out,
`endif
  output logic                flush_valid_out,
  output logic [ROB_SIZE-1:0] flush_mask_out,
  output logic                busy_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_br;
  logic                r_pend_vld;
  logic [PTR_W-1:0]    r_pend_idx;
  logic                r_valid;
  logic [ROB_SIZE-1:0] r_mask;
  logic                r_busy;

  // Lowest set bit wins. An all-zero tag yields 0, but it is filtered out by w_tag_ok.
  function automatic logic [PTR_W-1:0] f_tag2idx(input logic [ROB_SIZE-1:0] tag);
    f_tag2idx = '0;
    for (int i = ROB_SIZE - 1; i >= 0; i--) begin
      if (tag[i]) f_tag2idx = PTR_W'(i);
    end
  endfunction

  // Modular subtraction wraps naturally because ROB_SIZE == 2**PTR_W.
  function automatic logic [PTR_W-1:0] f_age(input logic [PTR_W-1:0] x,
                                             input logic [PTR_W-1:0] head);
    f_age = x - head;
  endfunction

  // The tail age needs one extra bit so that a full ROB (age ROB_SIZE) differs from an empty one.
  function automatic logic [ROB_SIZE-1:0] f_mask(input logic [PTR_W-1:0] br,
                                                 input logic [PTR_W-1:0] head,
                                                 input logic [PTR_W-1:0] tail,
                                                 input logic             full);
    logic [PTR_W:0]   tail_age;
    logic [PTR_W-1:0] br_age;
    logic [PTR_W-1:0] age_i;
    tail_age = full ? (PTR_W+1)'(ROB_SIZE) : {1'b0, f_age(tail, head)};
    br_age   = f_age(br, head);
    f_mask   = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      age_i     = f_age(PTR_W'(i), head);
      f_mask[i] = (age_i > br_age) && ({1'b0, age_i} < tail_age);
    end
  endfunction

  logic             w_tag_ok;
  logic             w_req;
  logic [PTR_W-1:0] w_idx;
  logic             w_older_br;
  logic             w_older_pend;
  logic             w_pend_nv;
  logic [PTR_W-1:0] w_pend_ni;

`ifdef SPECU_FLUSH_ONEHOT_CHECK_EN
  logic r_onehot_err;
  assign w_tag_ok = (misp_tag_in != '0) &&
                    ((misp_tag_in & (misp_tag_in - 1'b1)) == '0);
  assign onehot_err_out = r_onehot_err;
`else
  assign w_tag_ok = (misp_tag_in != '0);
`endif

  assign w_req        = misp_valid_in && w_tag_ok;
  assign w_idx        = f_tag2idx(misp_tag_in);
  // Ages are always re-derived from the current head, because the ROB may retire while we are busy.
  assign w_older_br   = f_age(w_idx, rob_head_in) < f_age(r_br, rob_head_in);
  assign w_older_pend = !r_pend_vld ||
                        (f_age(w_idx, rob_head_in) < f_age(r_pend_idx, rob_head_in));

  // Pending-slot update while in ISSUE. It is also used on the ack cycle, so a
  // request that arrives together with the ack is not lost.
  always_comb begin
    w_pend_nv = r_pend_vld;
    w_pend_ni = r_pend_idx;
    if (w_req && w_older_br && w_older_pend) begin
      w_pend_nv = 1'b1;
      w_pend_ni = w_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_br       <= '0;
      r_pend_vld <= 1'b0;
      r_pend_idx <= '0;
      r_valid    <= 1'b0;
      r_mask     <= '0;
      r_busy     <= 1'b0;
`ifdef SPECU_FLUSH_ONEHOT_CHECK_EN
      r_onehot_err <= 1'b0;
`endif
    end else begin
`ifdef SPECU_FLUSH_ONEHOT_CHECK_EN
      r_onehot_err <= misp_valid_in && !w_tag_ok;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_br    <= w_idx;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          // An older branch replaces the current one and costs one more CALC cycle.
          if (w_req && w_older_br) begin
            r_br <= w_idx;
          end else begin
            r_mask  <= f_mask(r_br, rob_head_in, rob_tail_in, rob_full_in);
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (flush_ack_in) begin
            r_valid <= 1'b0;
            r_mask  <= '0;
            if (w_pend_nv) begin
              r_br       <= w_pend_ni;
              r_pend_vld <= 1'b0;
              r_state    <= S_CALC;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_pend_vld <= w_pend_nv;
            r_pend_idx <= w_pend_ni;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign flush_valid_out = r_valid;
  assign flush_mask_out  = r_mask;
  assign busy_out        = r_busy;

endmodule

// File: tb/tb_specu_flush_mask_gen.sv
module tb_specu_flush_mask_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        misp_valid_in;
  logic [15:0] misp_tag_in;
  logic [3:0]  rob_head_in;
  logic [3:0]  rob_tail_in;
  logic        rob_full_in;
  logic        flush_ack_in;
  logic        flush_valid_out;
  logic [15:0] flush_mask_out;
  logic        busy_out;
`ifdef SPECU_FLUSH_ONEHOT_CHECK_EN
  logic        onehot_err_out;
`endif

  specu_flush_mask_gen #(.ROB_SIZE(16), .PTR_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .misp_valid_in   (misp_valid_in),
    .misp_tag_in     (misp_tag_in),
    .rob_head_in     (rob_head_in),
    .rob_tail_in     (rob_tail_in),
    .rob_full_in     (rob_full_in),
    .flush_ack_in    (flush_ack_in),
`ifdef SPECU_FLUSH_ONEHOT_CHECK_EN
    .onehot_err_out  (onehot_err_out),
`endif
    .flush_valid_out (flush_valid_out),
    .flush_mask_out  (flush_mask_out),
    .busy_out        (busy_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hs       = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Phase: 0 idle, 1 computing, 2 issuing. The mask is computed from the age rules with integer math.
  int          m_phase;
  int          m_br;
  bit          m_pv;
  int          m_pi;
  bit          m_valid;
  logic [15:0] m_mask;
  bit          m_busy;
  bit          m_err;

  function automatic int age(input int x, input int h);
    return (x - h + 16) % 16;
  endfunction

  function automatic int low_bit(input logic [15:0] t);
    for (int i = 0; i < 16; i++) if (t[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] ref_mask(input int br, input int h, input int t, input bit f);
    logic [15:0] m;
    int lim;
    lim = f ? 16 : age(t, h);
    m = '0;
    for (int i = 0; i < 16; i++)
      m[i] = (age(i, h) > age(br, h)) && (age(i, h) < lim);
    return m;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_br = 0; m_pv = 0; m_pi = 0;
    m_valid = 0; m_mask = '0; m_busy = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] tag, input int h,
                            input int t, input bit f, input bit a);
    bit ok;
    int idx;
`ifdef SPECU_FLUSH_ONEHOT_CHECK_EN
    ok = ($countones(tag) == 1);
`else
    ok = (tag != 0);
`endif
    m_err = v && !ok;
    ok = v && ok;
    idx = low_bit(tag);
    if (m_phase == 0) begin
      if (ok) begin m_br = idx; m_phase = 1; m_busy = 1; end
    end else if (m_phase == 1) begin
      if (ok && age(idx, h) < age(m_br, h)) m_br = idx;
      else begin m_mask = ref_mask(m_br, h, t, f); m_valid = 1; m_phase = 2; end
    end else begin
      if (ok && age(idx, h) < age(m_br, h) && (!m_pv || age(idx, h) < age(m_pi, h))) begin
        m_pv = 1; m_pi = idx;
      end
      if (a) begin
        m_valid = 0; m_mask = '0;
        if (m_pv) begin m_br = m_pi; m_pv = 0; m_phase = 1; end
        else begin m_phase = 0; m_busy = 0; end
      end
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit v, input logic [15:0] tag, input int h,
                     input int t, input bit f, input bit a);
    @(negedge clk);
    misp_valid_in = v;
    misp_tag_in   = tag;
    rob_head_in   = 4'(h);
    rob_tail_in   = 4'(t);
    rob_full_in   = f;
    flush_ack_in  = a;
    if (flush_valid_out && a) hs++;
    model_step(v, tag, h, t, f, a);
    @(posedge clk);
    #1;
    chk("valid", {31'd0, flush_valid_out}, {31'd0, m_valid});
    chk("mask",  {16'd0, flush_mask_out}, {16'd0, m_mask});
    chk("busy",  {31'd0, busy_out}, {31'd0, m_busy});
`ifdef SPECU_FLUSH_ONEHOT_CHECK_EN
    chk("onehot_err", {31'd0, onehot_err_out}, {31'd0, m_err});
`endif
  endtask

  task automatic idle(input int h, input int t, input bit f, input bit a);
    cyc(0, 16'h0, h, t, f, a);
  endtask

  initial begin
    logic [15:0] tg;
    int h, t;
    bit f;
    rst_n = 0; misp_valid_in = 0; misp_tag_in = 0; rob_head_in = 0;
    rob_tail_in = 0; rob_full_in = 0; flush_ack_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, flush_valid_out}, 32'd0);
    chk("rst_mask",  {16'd0, flush_mask_out}, 32'd0);
    chk("rst_busy",  {31'd0, busy_out}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Basic: head=2 tail=9 idx4 -> 0x01E0, held until ack
    cyc(1, 16'h0010, 2, 9, 0, 0);
    chk("t1_lat_n1", {31'd0, flush_valid_out}, 32'd0);
    idle(2, 9, 0, 0);
    chk("t1_valid", {31'd0, flush_valid_out}, 32'd1);
    chk("t1_mask", {16'd0, flush_mask_out}, 32'h01E0);
    idle(2, 9, 0, 0);
    idle(2, 9, 0, 0);
    chk("t1_hold", {16'd0, flush_mask_out}, 32'h01E0);
    idle(2, 9, 0, 1);
    chk("t1_done_busy", {31'd0, busy_out}, 32'd0);

    // Wrap: head=12 tail=3 idx14 -> 0x8007
    cyc(1, 16'h4000, 12, 3, 0, 0);
    idle(12, 3, 0, 0);
    chk("t2_mask", {16'd0, flush_mask_out}, 32'h8007);
    idle(12, 3, 0, 1);

    // Full ROB: youngest branch gives an empty but issued mask
    cyc(1, 16'h0010, 5, 5, 1, 0);
    idle(5, 5, 1, 0);
    chk("t3a_valid", {31'd0, flush_valid_out}, 32'd1);
    chk("t3a_mask", {16'd0, flush_mask_out}, 32'h0000);
    idle(5, 5, 1, 1);
    cyc(1, 16'h0040, 5, 5, 1, 0);
    idle(5, 5, 1, 0);
    chk("t3b_mask", {16'd0, flush_mask_out}, 32'hFF9F);
    idle(5, 5, 1, 1);

    // Overlap: idx8, then idx3 (older, pending), then idx10 (dropped)
    hs = 0;
    cyc(1, 16'h0100, 0, 0, 1, 0);
    idle(0, 0, 1, 0);
    chk("t4_first", {16'd0, flush_mask_out}, 32'hFE00);
    cyc(1, 16'h0008, 0, 0, 1, 0);
    cyc(1, 16'h0400, 0, 0, 1, 0);
    idle(0, 0, 1, 1);
    chk("t4_busy_kept", {31'd0, busy_out}, 32'd1);
    idle(0, 0, 1, 0);
    chk("t4_second", {16'd0, flush_mask_out}, 32'hFFF0);
    idle(0, 0, 1, 1);
    idle(0, 0, 1, 0);
    chk("t4_handshakes", 32'(hs), 32'd2);
    chk("t4_idle", {31'd0, busy_out}, 32'd0);

    // CALC replace: idx8 then idx5 -> idx5 only, valid one cycle later
    cyc(1, 16'h0100, 0, 0, 1, 0);
    cyc(1, 16'h0020, 0, 0, 1, 0);
    chk("t5_not_yet", {31'd0, flush_valid_out}, 32'd0);
    idle(0, 0, 1, 0);
    chk("t5_mask", {16'd0, flush_mask_out}, 32'hFFC0);
    idle(0, 0, 1, 1);

    // Async reset in ISSUE with a pending entry
    cyc(1, 16'h0100, 0, 0, 1, 0);
    idle(0, 0, 1, 0);
    cyc(1, 16'h0008, 0, 0, 1, 0);
    @(negedge clk);
    misp_valid_in = 0;
    #2 rst_n = 0;
    #1;
    chk("t6_valid", {31'd0, flush_valid_out}, 32'd0);
    chk("t6_mask", {16'd0, flush_mask_out}, 32'd0);
    chk("t6_busy", {31'd0, busy_out}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc(1, 16'h0010, 2, 9, 0, 0);
    idle(2, 9, 0, 0);
    chk("t6_after", {16'd0, flush_mask_out}, 32'h01E0);
    idle(2, 9, 0, 1);
    idle(2, 9, 0, 0);
    chk("t6_no_pending", {31'd0, busy_out}, 32'd0);

`ifdef SPECU_FLUSH_ONEHOT_CHECK_EN
    cyc(1, 16'h0011, 2, 9, 0, 0);
    chk("t6_err", {31'd0, onehot_err_out}, 32'd1);
    chk("t6_err_nobusy", {31'd0, busy_out}, 32'd0);
    idle(2, 9, 0, 0);
    chk("t6_err_pulse", {31'd0, onehot_err_out}, 32'd0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      h = $urandom_range(0, 15);
      f = ($urandom_range(0, 7) == 0);
      t = f ? h : $urandom_range(0, 15);
      case ($urandom_range(0, 9))
        0:       tg = 16'h0;
        1:       tg = 16'($urandom);
        default: tg = 16'h1 << $urandom_range(0, 15);
      endcase
      cyc($urandom_range(0, 2) == 0, tg, h, t, f, $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
